// File: rtl/spike_event_recorder.sv
// Synchronous FIFO with occupancy count; one push and one pop per cycle.
// Latency: a pushed entry is visible at pop_dat one cycle later (first-word-fall-through).
// Backpressure: push_rdy drops at full even if a pop happens in the same cycle.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_vld,
    input  logic [WIDTH-1:0]           push_dat,
    output logic                       push_rdy,
    output logic                       pop_vld,
    input  logic                       pop_rdy,
    output logic [WIDTH-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign push_rdy = (level != LVL_W'(DEPTH));
    assign pop_vld  = (level != '0);
    assign push     = push_vld & push_rdy;
    assign pop      = pop_vld & pop_rdy;
    // Head is forced to zero when empty so outputs are clean during and after reset.
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Timestamps per-column spikes and queues {time, column} events in a FIFO.
// Latency: spike captured at edge t appears at out_valid after edge t+1.
// Backpressure: full FIFO stalls pending columns; a repeat spike on a stalled column is dropped and counted.
module spike_event_recorder #(
    parameter int NUM_COLS   = 2,
    parameter int TIME_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          time_clear,
    input  logic [NUM_COLS-1:0]           spike_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [TIME_WIDTH-1:0]         out_time,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic [7:0]                    dropped_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CNT_W = 9 + $clog2(NUM_COLS + 1);

    typedef struct packed {
        logic [TIME_WIDTH-1:0] stamp;
        logic [ADDR_WIDTH-1:0] addr;
    } event_t;

    logic [TIME_WIDTH-1:0] time_cnt;
    logic [NUM_COLS-1:0]   pending;
    logic [TIME_WIDTH-1:0] stamp [NUM_COLS];

    logic                  grant_vld;
    logic [NUM_COLS-1:0]   grant_oh;
    event_t                push_evt;
    event_t                head_evt;
    logic                  push_rdy;
    logic                  push_fire;
    logic [NUM_COLS-1:0]   drain;
    logic [NUM_COLS-1:0]   spike_en;
    logic [NUM_COLS-1:0]   capture;
    logic [NUM_COLS-1:0]   drop;
    logic [CNT_W-1:0]      drop_total;
    logic [7:0]            dropped_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            time_cnt <= '0;
        end else if (time_clear) begin
            time_cnt <= '0;
        end else if (enable) begin
            time_cnt <= time_cnt + TIME_WIDTH'(1);
        end
    end

    // Descending scan so the lowest-index pending column wins.
    always_comb begin
        grant_vld      = 1'b0;
        grant_oh       = '0;
        push_evt.stamp = '0;
        push_evt.addr  = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (pending[c]) begin
                grant_vld      = 1'b1;
                grant_oh       = '0;
                grant_oh[c]    = 1'b1;
                push_evt.stamp = stamp[c];
                push_evt.addr  = ADDR_WIDTH'(c);
            end
        end
    end

    assign push_fire = grant_vld & push_rdy;
    assign drain     = push_fire ? grant_oh : '0;
    assign spike_en  = enable ? spike_in : '0;
    // A column drained this cycle can accept a fresh spike without loss.
    assign capture   = spike_en & (~pending | drain);
    assign drop      = spike_en & pending & ~drain;

    always_comb begin
        drop_total = CNT_W'(dropped_count);
        for (int c = 0; c < NUM_COLS; c++) begin
            drop_total = drop_total + CNT_W'(drop[c]);
        end
        dropped_next = (drop_total > CNT_W'(255)) ? 8'd255 : drop_total[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending       <= '0;
            dropped_count <= '0;
            for (int c = 0; c < NUM_COLS; c++) stamp[c] <= '0;
        end else begin
            pending       <= capture | (pending & ~drain);
            dropped_count <= dropped_next;
            for (int c = 0; c < NUM_COLS; c++) begin
                if (capture[c]) stamp[c] <= time_cnt;
            end
        end
    end

    event_fifo #(
        .WIDTH ($bits(event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (grant_vld),
        .push_dat (push_evt),
        .push_rdy (push_rdy),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_evt),
        .level    (fifo_level)
    );

    assign out_time = head_evt.stamp;
    assign out_addr = head_evt.addr;
endmodule

// File: tb/tb_spike_event_recorder.sv
// Bench for spike_event_recorder: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a queue-based reference model.
module tb_spike_event_recorder;
    localparam int NC = 2;
    localparam int TW = 4;
    localparam int FD = 8;
    localparam int AW = 1;
    localparam int TMOD = 1 << TW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          time_clear = 1'b0;
    logic [NC-1:0] spike_in = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [TW-1:0] out_time;
    logic [AW-1:0] out_addr;
    logic [7:0]    dropped_count;
    logic [$clog2(FD):0] fifo_level;

    int total = 0;
    int bad = 0;

    // Reference model state
    int m_cnt = 0;
    bit m_pend [NC];
    int m_stamp [NC];
    int m_qt [$];
    int m_qa [$];
    int m_drop = 0;
    int log_t [$];
    int log_a [$];

    spike_event_recorder #(
        .NUM_COLS   (NC),
        .TIME_WIDTH (TW),
        .FIFO_DEPTH (FD),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .time_clear    (time_clear),
        .spike_in      (spike_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_time      (out_time),
        .out_addr      (out_addr),
        .dropped_count (dropped_count),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_drop = 0;
        for (int c = 0; c < NC; c++) begin
            m_pend[c] = 1'b0;
            m_stamp[c] = 0;
        end
        m_qt.delete();
        m_qa.delete();
    endtask

    task automatic model_step();
        int lvl;
        int g;
        lvl = m_qt.size();
        g = -1;
        for (int c = NC - 1; c >= 0; c--) if (m_pend[c]) g = c;
        if (lvl > 0 && out_ready) begin
            log_t.push_back(m_qt[0]);
            log_a.push_back(m_qa[0]);
            void'(m_qt.pop_front());
            void'(m_qa.pop_front());
        end
        if (g >= 0 && lvl < FD) begin
            m_qt.push_back(m_stamp[g]);
            m_qa.push_back(g);
            m_pend[g] = 1'b0;
        end
        if (enable) begin
            for (int c = 0; c < NC; c++) begin
                if (spike_in[c]) begin
                    if (!m_pend[c]) begin
                        m_pend[c] = 1'b1;
                        m_stamp[c] = m_cnt;
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                end
            end
        end
        if (time_clear) m_cnt = 0;
        else if (enable) m_cnt = (m_cnt + 1) % TMOD;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_clear();
        else model_step();
    end

    always @(posedge clk) begin
        #1;
        check("valid", int'(out_valid), int'(m_qt.size() > 0));
        check("level", int'(fifo_level), m_qt.size());
        check("dropped", int'(dropped_count), m_drop);
        if (out_valid && m_qt.size() > 0) begin
            check("head_time", int'(out_time), m_qt[0]);
            check("head_addr", int'(out_addr), m_qa[0]);
        end
    end

    task automatic wait_cnt(input int v);
        int g;
        g = 0;
        while (m_cnt != v && g < 64) begin
            @(negedge clk);
            g++;
        end
        check("wait_cnt", m_cnt, v);
    endtask

    task automatic clear_log();
        log_t.delete();
        log_a.delete();
    endtask

    task automatic check_log(input string name, input int idx, input int t, input int a);
        if (idx < log_t.size()) begin
            check({name, "_t"}, log_t[idx], t);
            check({name, "_a"}, log_a[idx], a);
        end else begin
            check({name, "_present"}, log_t.size(), idx + 1);
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", int'(out_valid), 0);
        check("rst_time", int'(out_time), 0);
        check("rst_addr", int'(out_addr), 0);
        check("rst_dropped", int'(dropped_count), 0);
        check("rst_level", int'(fifo_level), 0);

        // Single spike on column 1 at counter 5
        reset = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        clear_log();
        repeat (5) @(negedge clk);
        check("pin_cnt5", m_cnt, 5);
        spike_in = 2'b10;
        @(negedge clk);
        spike_in = 2'b00;
        check("single_latency", int'(out_valid), 0);
        @(negedge clk);
        check("single_valid", int'(out_valid), 1);
        check("single_time", int'(out_time), 5);
        check("single_addr", int'(out_addr), 1);
        @(negedge clk);
        check("single_popped", int'(out_valid), 0);
        check_log("single_log", 0, 5, 1);

        // Simultaneous spikes at counter 10
        wait_cnt(10);
        spike_in = 2'b11;
        @(negedge clk);
        spike_in = 2'b00;
        @(negedge clk);
        check("simul_t0", int'(out_time), 10);
        check("simul_a0", int'(out_addr), 0);
        @(negedge clk);
        check("simul_t1", int'(out_time), 10);
        check("simul_a1", int'(out_addr), 1);
        check("simul_drop", int'(dropped_count), 0);

        // Overrun with a full FIFO and no consumer
        @(negedge clk);
        out_ready = 1'b0;
        time_clear = 1'b1;
        @(negedge clk);
        time_clear = 1'b0;
        spike_in = 2'b01;
        repeat (8) @(negedge clk);
        spike_in = 2'b00;
        @(negedge clk);
        check("full_level", int'(fifo_level), 8);
        spike_in = 2'b01;
        repeat (2) @(negedge clk);
        spike_in = 2'b00;
        repeat (2) @(negedge clk);
        check("overrun_drop", int'(dropped_count), 1);
        check("overrun_level", int'(fifo_level), 8);
        check("stall_valid", int'(out_valid), 1);
        check("stall_time", int'(out_time), 0);
        check("stall_addr", int'(out_addr), 0);
        clear_log();
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("drain_count", log_t.size(), 9);
        check_log("drain_first", 0, 0, 0);
        check_log("drain_eighth", 7, 7, 0);
        check_log("drain_held", 8, 9, 0);

        // Counter wrap then clear
        clear_log();
        wait_cnt(15);
        spike_in = 2'b10;
        repeat (2) @(negedge clk);
        spike_in = 2'b00;
        time_clear = 1'b1;
        @(negedge clk);
        time_clear = 1'b0;
        spike_in = 2'b01;
        @(negedge clk);
        spike_in = 2'b00;
        repeat (4) @(negedge clk);
        check_log("wrap_15", 0, 15, 1);
        check_log("wrap_0", 1, 0, 1);
        check_log("clear_0", 2, 0, 0);
        check("wrap_drop", int'(dropped_count), 1);

        // Reset with buffered events
        out_ready = 1'b0;
        spike_in = 2'b11;
        @(negedge clk);
        spike_in = 2'b01;
        @(negedge clk);
        spike_in = 2'b00;
        repeat (3) @(negedge clk);
        check("pre_reset_level", int'(fifo_level), 3);
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", int'(out_valid), 0);
        check("async_level", int'(fifo_level), 0);
        check("async_drop", int'(dropped_count), 0);
        check("async_time", int'(out_time), 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_valid", int'(out_valid), 0);
        check("post_reset_level", int'(fifo_level), 0);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(999) == 0) begin
                reset = 1'b0;
            end
            enable = ($urandom_range(9) != 0);
            time_clear = ($urandom_range(31) == 0);
            for (int c = 0; c < NC; c++) spike_in[c] = ($urandom_range(9) < 3);
            out_ready = (i % 400 < 150) ? 1'b0 : ($urandom_range(9) < 6);
        end
        @(negedge clk);
        reset = 1'b1;
        spike_in = '0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spike_event_recorder.md
SPIKE_EVENT_RECORDER -- requirements
Module: spike_event_recorder

Interface
REQ-001 SHALL have parameter NUM_COLS, default 2: number of neuron columns monitored.
REQ-002 SHALL have parameter TIME_WIDTH, default 16: timestamp width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries, power of 2, >=2.
REQ-004 SHALL have parameter ADDR_WIDTH, default 1: column address width, >= clog2(NUM_COLS), minimum 1.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  recording enable.
REQ-008 time_clear  in  1  synchronous timestamp-counter clear.
REQ-009 spike_in  in  NUM_COLS  one bit per column, high for one cycle per output spike.
REQ-010 out_valid  out  1  event available.
REQ-011 out_ready  in  1  consumer accepts the event.
REQ-012 out_time  out  TIME_WIDTH  timestamp of the head event.
REQ-013 out_addr  out  ADDR_WIDTH  column index of the head event.
REQ-014 dropped_count  out  8  saturating count of lost spikes.
REQ-015 fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Free-running counter: +1 per cycle while enable=1; holds while enable=0; wraps from 2^TIME_WIDTH-1 to 0.
REQ-017 time_clear=1 loads counter with 0 next edge; overrides increment; FIFO contents unaffected.
REQ-018 Capture: with enable=1, spike_in[c]=1 at edge t sets pending[c]; stamp[c] = counter value at edge t (pre-increment).
REQ-019 spike_in[c]=1 while pending[c] is set and not drained in the same cycle: spike lost; dropped_count +1, saturating at 255.
REQ-020 Same-cycle drain of pending[c] plus new spike_in[c]: new spike captured with fresh stamp; no drop.
REQ-021 With enable=0, spike_in ignored entirely: no capture, no drop count; pending entries and FIFO still drain.
REQ-022 Arbiter: each cycle, if any pending bit is set and FIFO not full, writes lowest-index pending column {stamp[c], c} to FIFO and clears pending[c].
REQ-023 Arbiter writes at most one event per cycle; higher columns wait; FIFO full stalls all pending bits, no loss.
REQ-024 FIFO: first-word-fall-through; out_valid=1 iff level>0; out_time/out_addr show head entry.
REQ-025 Pop on edge where out_valid=1 and out_ready=1; out_ready while out_valid=0 has no effect.
REQ-026 Simultaneous push and pop leave level unchanged; pushes refused when level=FIFO_DEPTH, even with a same-cycle pop.
REQ-027 Latency: lone spike at edge t into empty FIFO gives out_valid=1 after edge t+1.
REQ-028 out_time/out_addr stay stable while out_valid=1 and out_ready=0.
REQ-029 Read/write pointers wrap modulo FIFO_DEPTH; level distinguishes full from empty.

Reset
REQ-030 reset=0 asynchronously clears counter, pending, stamps, FIFO pointers, level, dropped_count.
REQ-031 During reset: out_valid=0, out_time=0, out_addr=0, dropped_count=0, fifo_level=0.
REQ-032 Reset mid-operation discards all pending and buffered events.
REQ-033 First counter increment on first clk edge after reset release with enable=1.

Verification
REQ-034 Single spike: reset, enable=1; spike_in=2'b10 at counter 5; out_ready=1 -> one event time=5, addr=1; out_valid 2 edges after capture.
REQ-035 Simultaneous spikes: spike_in=2'b11 at counter 10 -> events (10,0) then (10,1) on consecutive cycles; dropped_count=0.
REQ-036 Overrun: spike_in[0]=1 on two consecutive cycles, FIFO full, out_ready=0 -> dropped_count=1; after draining, one col-0 event holds first stamp.
REQ-037 Backpressure: out_ready=0, 10 isolated spikes, FIFO_DEPTH=8 -> fifo_level=8; out_valid steady; extra spikes stay pending or drop; release out_ready -> events drain in order.
REQ-038 Counter wrap/clear: TIME_WIDTH=4, spike at counter 15 then next cycle -> stamps 15, 0; time_clear pulse -> next capture stamp 0.
REQ-039 Reset mid-operation: 3 events buffered, assert reset -> out_valid=0, fifo_level=0 immediately, no stale events after release.
